// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer
//   Allocates incoming notes to a small pool of voice players, tracks how many
//   beats each voice still has to run, gathers one sample from every active
//   voice and mixes them into a single signed output sample.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   play_enable    global run; 0 freezes counts, gather and mix pipeline
//   note_to_load   note code for a new request (0 = rest)
//   duration       beat count for a new request
//   load_new_note  one-cycle load request
//   beat           one-cycle beat tick
//   voice_samples  packed samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_ready    per-voice sample-valid pulse
//   voice_load     one-hot load pulse to the voice players
//   voice_note     note of the most recently accepted request
//   voice_duration duration of the most recently accepted request
//   voice_active   bit i set while voice i has beats remaining
//   note_dropped   one-cycle pulse when a request finds no voice
//   note_done      high when no voice is active
//   final_sample   signed mixed sample
//   sample_ready   one-cycle pulse, final_sample valid
module poly_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int STEAL_EN   = 1,
    parameter int MIX_MODE   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play_enable,
    input  logic [NOTE_W-1:0]              note_to_load,
    input  logic [DUR_W-1:0]               duration,
    input  logic                           load_new_note,
    input  logic                           beat,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NOTE_W-1:0]              voice_note,
    output logic [DUR_W-1:0]               voice_duration,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic                           note_dropped,
    output logic                           note_done,
    output logic signed [SAMPLE_W-1:0]     final_sample,
    output logic                           sample_ready
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int K_W   = $clog2(NUM_VOICES + 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    // Voice bookkeeping
    logic [NUM_VOICES-1:0][DUR_W-1:0]    count_q, count_d;
    logic [NUM_VOICES-1:0]               voiceLoad_q, voiceLoad_d;
    logic [NOTE_W-1:0]                   voiceNote_q;
    logic [DUR_W-1:0]                    voiceDur_q;
    logic                                dropped_q;

    // Gather and mix pipeline
    logic [NUM_VOICES-1:0]               got_q, got_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0] sample_q, sample_d;
    logic signed [SUM_W-1:0]             sum_q, sum_d;
    logic [K_W-1:0]                      kCount_q, kCount_d;
    logic                                valid1_q;
    logic signed [SAMPLE_W-1:0]          final_q;
    logic                                ready_q;

    logic                                reqValid;
    logic                                freeFound;
    logic [IDX_W-1:0]                    freeIdx;
    logic [IDX_W-1:0]                    minIdx;
    logic [DUR_W-1:0]                    minCount;
    logic [IDX_W-1:0]                    targetIdx;
    logic                                accept;
    logic                                drop;
    logic [NUM_VOICES-1:0]               readyLive;
    logic [NUM_VOICES-1:0]               gotEff;
    logic                                gatherDone;
    logic [1:0]                          shiftAmt;
    logic signed [SAMPLE_W-1:0]          normSample;
    logic signed [SAMPLE_W-1:0]          satSample;
    logic signed [SAMPLE_W-1:0]          mixSample;

    // Activity is purely a decode of the beat counters
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active[i] = (count_q[i] != '0);
        end
        note_done = ~|voice_active;
    end

    // Voice selection: lowest free voice first; otherwise the voice closest
    // to finishing (strict compare keeps ties on the lowest index).
    always_comb begin
        reqValid  = load_new_note & play_enable & (|note_to_load) & (|duration);
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (count_q[i] == '0) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
        minIdx   = '0;
        minCount = count_q[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (count_q[i] < minCount) begin
                minCount = count_q[i];
                minIdx   = IDX_W'(i);
            end
        end
        targetIdx = freeFound ? freeIdx : minIdx;
        accept    = reqValid & (freeFound | (STEAL_EN != 0));
        drop      = reqValid & ~freeFound & (STEAL_EN == 0);
    end

    // A load wins over a simultaneous beat on the target voice only
    always_comb begin
        voiceLoad_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_d[i] = count_q[i];
            if (accept && (targetIdx == IDX_W'(i))) begin
                count_d[i]     = duration;
                voiceLoad_d[i] = 1'b1;
            end else if (beat && (count_q[i] != '0)) begin
                count_d[i] = count_q[i] - DUR_W'(1);
            end
        end
    end

    // Beat counters, frozen while play is paused
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (play_enable) begin
            count_q <= count_d;
        end
    end

    // Load handshake towards the voice players
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            voiceLoad_q <= '0;
            voiceNote_q <= '0;
            voiceDur_q  <= '0;
            dropped_q   <= 1'b0;
        end else begin
            voiceLoad_q <= voiceLoad_d;
            dropped_q   <= drop;
            if (accept) begin
                voiceNote_q <= note_to_load;
                voiceDur_q  <= duration;
            end
        end
    end

    // Gather: a ready arriving this cycle counts towards completion now, so
    // the mix starts in the same cycle as the last contributing sample.
    // got bits of inactive voices are masked out of both completion and sum.
    always_comb begin
        readyLive  = voice_ready & voice_active & {NUM_VOICES{play_enable}};
        gotEff     = (got_q & voice_active) | readyLive;
        gatherDone = play_enable & (&(gotEff | ~voice_active)) & (|gotEff);
        got_d      = gatherDone ? '0 : gotEff;
        sum_d      = '0;
        kCount_d   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sample_d[i] = readyLive[i] ? voice_samples[i*SAMPLE_W +: SAMPLE_W]
                                       : sample_q[i];
            if (gotEff[i]) begin
                sum_d    = sum_d + {{(SUM_W-SAMPLE_W){sample_d[i][SAMPLE_W-1]}},
                                    sample_d[i]};
                kCount_d = kCount_d + K_W'(1);
            end
        end
    end

    // Gather state and stage 1 (sum and contributor count)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            got_q    <= '0;
            sample_q <= '0;
            sum_q    <= '0;
            kCount_q <= '0;
            valid1_q <= 1'b0;
        end else if (play_enable) begin
            got_q    <= got_d;
            sample_q <= sample_d;
            valid1_q <= gatherDone;
            if (gatherDone) begin
                sum_q    <= sum_d;
                kCount_q <= kCount_d;
            end
        end
    end

    // Normalising shift approximates division by the contributor count
    always_comb begin
        if (int'(kCount_q) <= 1) begin
            shiftAmt = 2'd0;
        end else if (int'(kCount_q) == 2) begin
            shiftAmt = 2'd1;
        end else if (int'(kCount_q) <= 4) begin
            shiftAmt = 2'd2;
        end else begin
            shiftAmt = 2'd3;
        end
        normSample = SAMPLE_W'(sum_q >>> shiftAmt);
        if (sum_q > SAT_MAX) begin
            satSample = SAT_MAX[SAMPLE_W-1:0];
        end else if (sum_q < SAT_MIN) begin
            satSample = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            satSample = sum_q[SAMPLE_W-1:0];
        end
        mixSample = (MIX_MODE != 0) ? satSample : normSample;
    end

    // Stage 2: silence wins once every voice has finished; sample_ready is
    // kept a single-cycle pulse even while paused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            final_q <= '0;
            ready_q <= 1'b0;
        end else if (note_done) begin
            final_q <= '0;
            ready_q <= 1'b0;
        end else if (play_enable) begin
            ready_q <= valid1_q;
            if (valid1_q) begin
                final_q <= mixSample;
            end
        end else begin
            ready_q <= 1'b0;
        end
    end

    assign voice_load     = voiceLoad_q;
    assign voice_note     = voiceNote_q;
    assign voice_duration = voiceDur_q;
    assign note_dropped   = dropped_q;
    assign final_sample   = final_q;
    assign sample_ready   = ready_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// tb_poly_voice_mixer
//   Directed bench for poly_voice_mixer. Two instances share every input:
//   'dut' uses the default parameters (voice stealing, normalised mix) and
//   'dutAlt' drops notes when full and uses the saturating mix.
`timescale 1ns/1ps
module tb_poly_voice_mixer;

    localparam int NV = 4;
    localparam int SW = 16;
    localparam int NW = 6;
    localparam int DW = 6;

    logic                 clock = 1'b0;
    logic                 resetN;
    logic                 playEnable;
    logic [NW-1:0]        noteToLoad;
    logic [DW-1:0]        durationIn;
    logic                 loadNewNote;
    logic                 beatIn;
    logic [NV*SW-1:0]     voiceSamples;
    logic [NV-1:0]        voiceReady;

    logic [NV-1:0]        mVoiceLoad, aVoiceLoad;
    logic [NW-1:0]        mVoiceNote, aVoiceNote;
    logic [DW-1:0]        mVoiceDur, aVoiceDur;
    logic [NV-1:0]        mActive, aActive;
    logic                 mDropped, aDropped;
    logic                 mDone, aDone;
    logic signed [SW-1:0] mFinal, aFinal;
    logic                 mReady, aReady;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clock = ~clock;

    poly_voice_mixer dut (
        .clk(clock), .reset(resetN), .play_enable(playEnable),
        .note_to_load(noteToLoad), .duration(durationIn),
        .load_new_note(loadNewNote), .beat(beatIn),
        .voice_samples(voiceSamples), .voice_ready(voiceReady),
        .voice_load(mVoiceLoad), .voice_note(mVoiceNote),
        .voice_duration(mVoiceDur), .voice_active(mActive),
        .note_dropped(mDropped), .note_done(mDone),
        .final_sample(mFinal), .sample_ready(mReady)
    );

    poly_voice_mixer #(.STEAL_EN(0), .MIX_MODE(1)) dutAlt (
        .clk(clock), .reset(resetN), .play_enable(playEnable),
        .note_to_load(noteToLoad), .duration(durationIn),
        .load_new_note(loadNewNote), .beat(beatIn),
        .voice_samples(voiceSamples), .voice_ready(voiceReady),
        .voice_load(aVoiceLoad), .voice_note(aVoiceNote),
        .voice_duration(aVoiceDur), .voice_active(aActive),
        .note_dropped(aDropped), .note_done(aDone),
        .final_sample(aFinal), .sample_ready(aReady)
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and land just after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One-cycle load request
    task automatic applyStimulus(input logic [NW-1:0] note, input logic [DW-1:0] dur);
        noteToLoad  = note;
        durationIn  = dur;
        loadNewNote = 1'b1;
        step();
        loadNewNote = 1'b0;
    endtask

    task automatic beatTicks(input int n);
        beatIn = 1'b1;
        repeat (n) step();
        beatIn = 1'b0;
    endtask

    task automatic setSample(input int idx, input int value);
        logic [31:0] v;
        v = value;
        voiceSamples[idx*SW +: SW] = v[SW-1:0];
    endtask

    initial begin
        resetN       = 1'b0;
        playEnable   = 1'b0;
        noteToLoad   = '0;
        durationIn   = '0;
        loadNewNote  = 1'b0;
        beatIn       = 1'b0;
        voiceSamples = '0;
        voiceReady   = '0;

        // Values held during reset
        step();
        step();
        checkOutput("rst voice_load", int'(mVoiceLoad), 0);
        checkOutput("rst voice_note", int'(mVoiceNote), 0);
        checkOutput("rst voice_duration", int'(mVoiceDur), 0);
        checkOutput("rst voice_active", int'(mActive), 0);
        checkOutput("rst note_dropped", int'(mDropped), 0);
        checkOutput("rst final_sample", int'(mFinal), 0);
        checkOutput("rst sample_ready", int'(mReady), 0);
        checkOutput("rst note_done", int'(mDone), 1);
        resetN     = 1'b1;
        playEnable = 1'b1;
        step();

        // Three loads on consecutive cycles fill voices 0, 1, 2
        applyStimulus(6'd3, 6'd2);
        checkOutput("load1 voice_load", int'(mVoiceLoad), 'b0001);
        checkOutput("load1 voice_note", int'(mVoiceNote), 3);
        checkOutput("load1 voice_duration", int'(mVoiceDur), 2);
        applyStimulus(6'd4, 6'd3);
        checkOutput("load2 voice_load", int'(mVoiceLoad), 'b0010);
        applyStimulus(6'd5, 6'd4);
        checkOutput("load3 voice_load", int'(mVoiceLoad), 'b0100);
        step();
        checkOutput("load idle voice_load", int'(mVoiceLoad), 0);
        checkOutput("three active", int'(mActive), 'b0111);
        checkOutput("three note_done", int'(mDone), 0);
        beatTicks(2);
        checkOutput("after 2 beats active", int'(mActive), 'b0110);
        beatTicks(2);
        checkOutput("drained note_done", int'(mDone), 1);

        // Requests that must be ignored
        applyStimulus(6'd0, 6'd5);
        checkOutput("rest voice_load", int'(mVoiceLoad), 0);
        checkOutput("rest dropped alt", int'(aDropped), 0);
        applyStimulus(6'd7, 6'd0);
        checkOutput("zero dur voice_load", int'(mVoiceLoad), 0);
        checkOutput("zero dur dropped alt", int'(aDropped), 0);
        playEnable = 1'b0;
        applyStimulus(6'd7, 6'd5);
        checkOutput("paused voice_load", int'(mVoiceLoad), 0);
        playEnable = 1'b1;
        step();
        checkOutput("ignored active", int'(mActive), 0);

        // Counts 5,2,7,2 then a fifth note: steal voice 1 or drop
        applyStimulus(6'd1, 6'd5);
        applyStimulus(6'd2, 6'd2);
        applyStimulus(6'd3, 6'd7);
        applyStimulus(6'd4, 6'd2);
        checkOutput("fill voice_load", int'(mVoiceLoad), 'b1000);
        applyStimulus(6'd9, 6'd6);
        checkOutput("steal voice_load", int'(mVoiceLoad), 'b0010);
        checkOutput("steal voice_note", int'(mVoiceNote), 9);
        checkOutput("steal voice_duration", int'(mVoiceDur), 6);
        checkOutput("steal dropped", int'(mDropped), 0);
        checkOutput("drop voice_load alt", int'(aVoiceLoad), 0);
        checkOutput("drop pulse alt", int'(aDropped), 1);
        checkOutput("drop voice_note alt", int'(aVoiceNote), 4);
        step();
        checkOutput("drop pulse ends alt", int'(aDropped), 0);
        beatTicks(2);
        checkOutput("steal active 2 beats", int'(mActive), 'b0111);
        checkOutput("drop active 2 beats alt", int'(aActive), 'b0101);
        beatTicks(3);
        checkOutput("steal active 5 beats", int'(mActive), 'b0110);
        checkOutput("drop active 5 beats alt", int'(aActive), 'b0100);
        beatTicks(2);
        checkOutput("steal drained", int'(mDone), 1);
        checkOutput("drop drained alt", int'(aDone), 1);

        // Two voices, readies three cycles apart
        applyStimulus(6'd1, 6'd20);
        applyStimulus(6'd2, 6'd20);
        setSample(0, 1000);
        voiceReady = 4'b0001;
        step();
        voiceReady = 4'b0000;
        step();
        step();
        setSample(1, 3000);
        voiceReady = 4'b0010;
        step();
        voiceReady = 4'b0000;
        checkOutput("mix2 early ready", int'(mReady), 0);
        step();
        checkOutput("mix2 sample_ready", int'(mReady), 1);
        checkOutput("mix2 final norm", int'(mFinal), 2000);
        checkOutput("mix2 final sat alt", int'(aFinal), 4000);
        step();
        checkOutput("mix2 ready pulse ends", int'(mReady), 0);

        // Three voices: normalise versus saturate, both polarities
        applyStimulus(6'd3, 6'd20);
        checkOutput("third voice_load", int'(mVoiceLoad), 'b0100);
        setSample(0, 12000);
        setSample(1, 12000);
        setSample(2, 12000);
        voiceReady = 4'b0111;
        step();
        voiceReady = 4'b0000;
        step();
        checkOutput("mix3 sample_ready", int'(mReady), 1);
        checkOutput("mix3 final norm", int'(mFinal), 9000);
        checkOutput("mix3 final sat alt", int'(aFinal), 32767);
        setSample(0, -30000);
        setSample(1, -10000);
        setSample(2, 0);
        voiceReady = 4'b0111;
        step();
        voiceReady = 4'b0000;
        step();
        checkOutput("neg final norm", int'(mFinal), -10000);
        checkOutput("neg final sat alt", int'(aFinal), -32768);

        // All voices finish: output drops to silence
        beatTicks(20);
        checkOutput("finish note_done", int'(mDone), 1);
        step();
        checkOutput("silence final", int'(mFinal), 0);
        checkOutput("silence final alt", int'(aFinal), 0);
        checkOutput("silence ready", int'(mReady), 0);

        // Reset one cycle after gather completes discards the mix
        applyStimulus(6'd1, 6'd10);
        applyStimulus(6'd2, 6'd10);
        setSample(0, 500);
        setSample(1, 700);
        voiceReady = 4'b0011;
        step();
        voiceReady = 4'b0000;
        resetN     = 1'b0;
        #1;
        checkOutput("midpipe rst ready", int'(mReady), 0);
        checkOutput("midpipe rst final", int'(mFinal), 0);
        checkOutput("midpipe rst note_done", int'(mDone), 1);
        step();
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post rst ready", int'(mReady), 0);
            checkOutput("post rst final", int'(mFinal), 0);
        end
        checkOutput("post rst active", int'(mActive), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
